// File: rtl/timecode_encoder.sv
// timecode_encoder: assembles the 80-bit timecode packet from discrete
// hours/minutes/seconds/frames/user fields.
// The packet checksum makes the bytes of bits [63:0] sum to 8'hFF.
// One byte is summed per cycle. The finished packet is held on a valid/ready output.
// Optional build macro TC_RANGE_CHECK_EN: when defined, out-of-range field
// sets are consumed, dropped, and flagged with a one-cycle err pulse.
module timecode_encoder #(
    parameter logic FLAG_VAL    = 1'b1,
    parameter int   FRAME_LIMIT = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  hours,
    input  logic [6:0]  minutes,
    input  logic [6:0]  seconds,
    input  logic [23:0] frames,
    input  logic [28:0] user_bits,
    output logic [79:0] timecode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, SUM, SEAL, SEND} state_t;

    state_t      state_q, state_d;
    logic [79:0] tc_q, tc_d;
    logic [7:0]  acc_q, acc_d;
    logic [2:0]  idx_q, idx_d;
    logic        out_valid_q, out_valid_d;
    logic        err_q, err_d;
    logic        range_bad;
    logic [6:0]  byte_lsb;

    // Field range check: compiled in only with the optional feature.
`ifdef TC_RANGE_CHECK_EN
    assign range_bad = (minutes > 7'd59) || (seconds > 7'd59) ||
                       (frames >= 24'(FRAME_LIMIT));
`else
    assign range_bad = 1'b0;
`endif

    // Bit offset of the byte summed in the current SUM cycle.
    assign byte_lsb = {1'b0, idx_q, 3'b000};

    // Next-state logic: latch, sum bytes 1..7, seal the checksum, then hold for handshake.
    always_comb begin
        state_d     = state_q;
        tc_d        = tc_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (range_bad) begin
                        err_d = 1'b1;
                    end else begin
                        tc_d    = {FLAG_VAL, hours, minutes, seconds, frames, user_bits, 8'h00};
                        acc_d   = 8'h00;
                        idx_d   = 3'd1;
                        state_d = SUM;
                    end
                end
            end
            SUM: begin
                acc_d = acc_q + tc_q[byte_lsb +: 8];
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd7) state_d = SEAL;
            end
            SEAL: begin
                tc_d[7:0]   = 8'hFF - acc_q;
                out_valid_d = 1'b1;
                state_d     = SEND;
            end
            SEND: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any packet in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            tc_q        <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tc_q        <= tc_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign timecode  = tc_q;
    assign out_valid = out_valid_q;
`ifdef TC_RANGE_CHECK_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_timecode_encoder.sv
// tb_timecode_encoder: directed tests of the timecode encoder.
// dut uses FLAG_VAL=1 and dut0 uses FLAG_VAL=0; both share the same stimulus.
module tb_timecode_encoder;

    localparam logic [79:0] P_MAIN = 80'h9AD1_8000_0200_0000_007D;
    localparam logic [79:0] P_ZERO = 80'h8000_0000_0000_0000_00FF;
    localparam logic [79:0] P_USER = 80'h8000_0000_001F_FFFF_FFE3;
    localparam logic [79:0] P_M60  = 80'h83C0_0000_0000_0000_00FF;
    localparam logic [79:0] P_F29  = 80'h8000_0000_03A0_0000_005C;
    localparam logic [79:0] FLAG   = {1'b1, 79'b0};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [3:0]  hours = '0;
    logic [6:0]  minutes = '0;
    logic [6:0]  seconds = '0;
    logic [23:0] frames = '0;
    logic [28:0] user_bits = '0;
    logic        in_ready, out_valid, busy, err;
    logic [79:0] timecode;
    logic        in_ready0, out_valid0, busy0, err0;
    logic [79:0] timecode0;

    int tests = 0;
    int fails = 0;

    timecode_encoder #(.FLAG_VAL(1'b1), .FRAME_LIMIT(30)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .hours(hours), .minutes(minutes), .seconds(seconds), .frames(frames),
        .user_bits(user_bits), .timecode(timecode), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .err(err)
    );

    timecode_encoder #(.FLAG_VAL(1'b0), .FRAME_LIMIT(30)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .hours(hours), .minutes(minutes), .seconds(seconds), .frames(frames),
        .user_bits(user_bits), .timecode(timecode0), .out_valid(out_valid0),
        .out_ready(out_ready), .busy(busy0), .err(err0)
    );

    always #5 clk = ~clk;

    // Present one field set for a single accepting edge; returns in cycle 1.
    task automatic offer(input logic [3:0] h, input logic [6:0] m, input logic [6:0] s,
                         input logic [23:0] f, input logic [28:0] u);
        hours = h; minutes = m; seconds = s; frames = f; user_bits = u;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Count cycles from cycle 1 until out_valid, bounded.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
    endtask

    function automatic logic [7:0] byte_sum(input logic [79:0] p);
        logic [7:0] s = 8'h00;
        for (int i = 0; i < 8; i++) s = s + p[i*8 +: 8];
        return s;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests++; if (timecode !== 80'h0) begin fails++; $display("FAIL reset_timecode: got %h expected 0", timecode); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", err); end
    endtask

    task automatic test_basic();
        int lat;
        out_ready = 1'b1;
        offer(4'd3, 7'd45, 7'd12, 24'h000010, 29'h0);
        tests++; if (busy !== 1'b1 || in_ready !== 1'b0) begin fails++; $display("FAIL basic_busy: got busy=%b in_ready=%b expected 1/0", busy, in_ready); end
        wait_valid(lat);
        tests++; if (lat != 9) begin fails++; $display("FAIL basic_latency: got %0d expected 9", lat); end
        tests++; if (timecode !== P_MAIN) begin fails++; $display("FAIL basic_packet: got %h expected %h", timecode, P_MAIN); end
        tests++; if (timecode[79:75] !== 5'b10011) begin fails++; $display("FAIL basic_flag_hours: got %b expected 10011", timecode[79:75]); end
        tests++; if (byte_sum(timecode) !== 8'hFF) begin fails++; $display("FAIL basic_bytesum: got %h expected ff", byte_sum(timecode)); end
        tests++; if (timecode0 !== (P_MAIN ^ FLAG)) begin fails++; $display("FAIL basic_flag0_packet: got %h expected %h", timecode0, P_MAIN ^ FLAG); end
        @(negedge clk);
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL basic_handshake: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready); end
    endtask

    task automatic test_zero();
        int lat;
        offer(4'd0, 7'd0, 7'd0, 24'h0, 29'h0);
        wait_valid(lat);
        tests++; if (lat != 9) begin fails++; $display("FAIL zero_latency: got %0d expected 9", lat); end
        tests++; if (timecode !== P_ZERO) begin fails++; $display("FAIL zero_packet: got %h expected %h", timecode, P_ZERO); end
        tests++; if (timecode0 !== (P_ZERO ^ FLAG)) begin fails++; $display("FAIL zero_flag0_packet: got %h expected %h", timecode0, P_ZERO ^ FLAG); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat;
        int bad;
        out_ready = 1'b0;
        offer(4'd3, 7'd45, 7'd12, 24'h000010, 29'h0);
        wait_valid(lat);
        tests++; if (lat != 9) begin fails++; $display("FAIL bp_latency: got %0d expected 9", lat); end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (timecode !== P_MAIN || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL bp_hold: got %0d bad cycles expected 0", bad); end
        // Offer the next field set while still in SEND; it must wait for IDLE.
        hours = 4'd0; minutes = 7'd0; seconds = 7'd0; frames = 24'h0; user_bits = 29'h1FFF_FFFF;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL bp_release: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_accept: got busy=%b expected 1", busy); end
        wait_valid(lat);
        tests++; if (lat != 9) begin fails++; $display("FAIL b2b_latency: got %0d expected 9", lat); end
        tests++; if (timecode !== P_USER) begin fails++; $display("FAIL b2b_packet: got %h expected %h", timecode, P_USER); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen;
        offer(4'd3, 7'd45, 7'd12, 24'h000010, 29'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tests++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL mid_reset_state: got busy=%b out_valid=%b in_ready=%b expected 0/0/1", busy, out_valid, in_ready); end
        tests++; if (timecode !== 80'h0) begin fails++; $display("FAIL mid_reset_timecode: got %h expected 0", timecode); end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        tests++; if (seen != 0) begin fails++; $display("FAIL mid_reset_no_output: got %0d valid cycles expected 0", seen); end
        offer(4'd0, 7'd0, 7'd0, 24'd29, 29'h0);
        wait_valid(lat);
        tests++; if (timecode !== P_F29 || lat != 9) begin fails++; $display("FAIL mid_reset_next_packet: got %h lat %0d expected %h lat 9", timecode, lat, P_F29); end
        @(negedge clk);
    endtask

    task automatic test_range();
        int lat;
`ifdef TC_RANGE_CHECK_EN
        int seen;
        offer(4'd0, 7'd60, 7'd0, 24'h0, 29'h0);
        tests++; if (err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL range_err_pulse: got err=%b busy=%b in_ready=%b expected 1/0/1", err, busy, in_ready); end
        @(negedge clk);
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL range_err_width: got %b expected 0", err); end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        tests++; if (seen != 0) begin fails++; $display("FAIL range_dropped: got %0d valid cycles expected 0", seen); end
`else
        offer(4'd0, 7'd60, 7'd0, 24'h0, 29'h0);
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL range_err_tied: got %b expected 0", err); end
        wait_valid(lat);
        tests++; if (timecode !== P_M60 || lat != 9) begin fails++; $display("FAIL range_unchecked_packet: got %h lat %0d expected %h lat 9", timecode, lat, P_M60); end
        @(negedge clk);
`endif
        offer(4'd0, 7'd0, 7'd0, 24'd29, 29'h0);
        wait_valid(lat);
        tests++; if (timecode !== P_F29 || lat != 9) begin fails++; $display("FAIL range_frames29: got %h lat %0d expected %h lat 9", timecode, lat, P_F29); end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_zero();
        test_back_to_back();
        test_reset_mid();
        test_range();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
